serial_nibble_adder: RTL and testbench

Multi-cycle unsigned/two's-complement adder that builds a wide sum from a chain of 4-bit additions, one nibble per clock, least-significant nibble first. It sits directly upstream of the team's 4-bit adder datapath. It sequences operand nibbles into the adder, feeds each nibble's carry-out back as the next carry-in, and assembles the result. It presents valid/ready handshakes on both sides so it can drop into the BMU arithmetic path.

---
 rtl/serial_add_pkg.sv | 19 +
 rtl/serial_nibble_adder_nibble_add.sv | 22 ++
 rtl/serial_nibble_adder.sv | 116 +++++++++++
 tb/tb_serial_nibble_adder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types and constants for the nibble-serial adder.
//   NIBBLE_W   - width of one adder step
//   sa_state_t - control FSM states
//   cnt_w()    - nibble counter width for a given operand size
package serial_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    function automatic int cnt_w(input int nibbles);
        return $clog2(nibbles);
    endfunction

endpackage

// File: rtl/serial_nibble_adder_nibble_add.sv
// nibble_add: combinational 4-bit adder with carry in/out.
//   ina, inb  - nibble operands
//   carry_in  - carry into bit 0
//   sum_out   - 4-bit sum
//   carry_out - carry out of bit 3
module nibble_add
    import serial_add_pkg::*;
(
    input  logic [NIBBLE_W-1:0] ina,
    input  logic [NIBBLE_W-1:0] inb,
    input  logic                carry_in,
    output logic [NIBBLE_W-1:0] sum_out,
    output logic                carry_out
);

    logic [NIBBLE_W:0] full;

    assign full      = {1'b0, ina} + {1'b0, inb} + {{NIBBLE_W{1'b0}}, carry_in};
    assign sum_out   = full[NIBBLE_W-1:0];
    assign carry_out = full[NIBBLE_W];

endmodule

// File: rtl/serial_nibble_adder.sv
// serial_nibble_adder: W-bit add built from NIBBLES sequential 4-bit steps,
// least-significant nibble first, with valid/ready on both sides.
//   clk, rst_n           - clock, async active-low reset
//   in_valid/in_ready    - operand handshake (ready only in IDLE)
//   in_a, in_b, in_cin   - operands, captured at the accepting edge
//   out_valid/out_ready  - result handshake (valid only in DONE)
//   out_sum, out_cout    - A + B + cin mod 2^W and its unsigned carry
//   out_ovf              - signed overflow of the sum
module serial_nibble_adder
    import serial_add_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NIBBLES-1:0]    in_a,
    input  logic [4*NIBBLES-1:0]    in_b,
    input  logic                    in_cin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NIBBLES-1:0]    out_sum,
    output logic                    out_cout,
    output logic                    out_ovf
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int CW = cnt_w(NIBBLES);

    sa_state_t               state, nxt;
    logic [W-1:0]            a_sr, b_sr;
    // Only the upper W-4 bits of the partial sum need storing: the nibble
    // produced this cycle is concatenated on top to form the full window.
    logic [W-NIBBLE_W-1:0]   sum_sr;
    logic [W-1:0]            sum_nxt;
    logic                    carry;
    logic [CW-1:0]           cnt;
    logic                    a_msb, b_msb;
    logic                    last;
    logic [NIBBLE_W-1:0]     nib;
    logic                    nib_cout;

    nibble_add u_add (
        .ina       (a_sr[NIBBLE_W-1:0]),
        .inb       (b_sr[NIBBLE_W-1:0]),
        .carry_in  (carry),
        .sum_out   (nib),
        .carry_out (nib_cout)
    );

    assign sum_nxt   = {nib, sum_sr};
    assign last      = (cnt == CW'(NIBBLES - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (in_valid)  nxt = RUN;
            RUN:     if (last)      nxt = DONE;
            DONE:    if (out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            sum_sr   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr   <= in_a;
                        b_sr   <= in_b;
                        sum_sr <= '0;
                        carry  <= in_cin;
                        cnt    <= '0;
                        a_msb  <= in_a[W-1];
                        b_msb  <= in_b[W-1];
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> NIBBLE_W;
                    b_sr   <= b_sr >> NIBBLE_W;
                    sum_sr <= sum_nxt[W-1:NIBBLE_W];
                    carry  <= nib_cout;
                    cnt    <= cnt + CW'(1);
                    // Result registers update only on the final step, so they
                    // hold the previous result through IDLE and the next RUN.
                    if (last) begin
                        out_sum  <= sum_nxt;
                        out_cout <= nib_cout;
                        out_ovf  <= (a_msb == b_msb) && (nib[NIBBLE_W-1] != a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_nibble_adder.sv
module tb_serial_nibble_adder;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_cin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          out_ovf;

    serial_nibble_adder #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   n_push = 0;
    int   n_pop = 0;
    int   n_flush = 0;
    int   last_acc = 0;
    int   last_hs = 0;
    int   rdy_mode = 0;  // 0: ready high, 1: random, 2: driven by main

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Reference: plain integer add, signed rule on the operand/sum MSBs.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        exp_t e;
        logic [W:0] full;
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
        e.acc  = 0;
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1)      out_ready = 1'($urandom_range(0, 1));
        else if (rdy_mode == 0) out_ready = 1'b1;
    end

    // Monitor: latency on rising valid, hold-stability under backpressure,
    // scoreboard compare on each output handshake.
    logic         prev_valid = 1'b0;
    logic [W-1:0] hold_sum;
    logic         hold_cout, hold_ovf;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (exp_q.size() == 0) chk("valid_without_issue", 1, 0);
                else                   chk("latency", 32'(cyc - exp_q[0].acc), N);
            end
            if (out_valid && prev_valid) begin
                chk("hold_sum", out_sum, hold_sum);
                chk("hold_cout", out_cout, hold_cout);
                chk("hold_ovf", out_ovf, hold_ovf);
            end
            if (out_valid) begin
                hold_sum  = out_sum;
                hold_cout = out_cout;
                hold_ovf  = out_ovf;
            end
            if (out_valid && out_ready) begin
                last_hs = cyc + 1;
                if (exp_q.size() == 0) begin
                    chk("extra_result", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    n_pop++;
                    chk("sum", out_sum, e.sum);
                    chk("cout", out_cout, e.cout);
                    chk("ovf", out_ovf, e.ovf);
                end
            end
            prev_valid = out_valid && !out_ready;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int   n;
        bit   acc;
        exp_t e;
        n = 0;
        acc = 0;
        in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
        while (!acc && n < 40) begin
            @(negedge clk);
            n++;
            if (in_ready) begin
                @(posedge clk);
                #1;
                acc = 1;
            end
        end
        in_valid = 1'b0;
        if (!acc) begin
            chk("accept_timeout", 0, 1);
        end else begin
            e = model(a, b, c);
            e.acc = cyc;
            last_acc = cyc;
            exp_q.push_back(e);
            n_push++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 0);
    endtask

    initial begin
        int n;
        // Reset state
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_cout", out_cout, 0);
        chk("rst_out_ovf", out_ovf, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Carry ripple through all nibbles, then signed-overflow cases
        do_op(16'hFFFF, 16'h0001, 1'b0);
        do_op(16'hFFFF, 16'hFFFF, 1'b1);
        do_op(16'h7FFF, 16'h0001, 1'b0);
        do_op(16'h8000, 16'h8000, 1'b0);
        drain();

        // Backpressure with new operands waiting
        rdy_mode = 2;
        out_ready = 1'b0;
        do_op(16'h1357, 16'h2468, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reach_done", out_valid, 1);
        in_a = 16'hAAAA; in_b = 16'h5555; in_cin = 1'b1; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        rdy_mode = 0;
        do_op(16'hAAAA, 16'h5555, 1'b1);
        chk("bp_accept_after_idle", 32'(last_acc), 32'(last_hs + 1));
        drain();

        // Reset two edges into RUN
        do_op(16'h1234, 16'h1111, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_sum", out_sum, 0);
        chk("midrst_out_cout", out_cout, 0);
        n_flush += exp_q.size();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(16'h1234, 16'h1111, 1'b0);
        drain();

        // Operand change during RUN is ignored
        do_op(16'h0F0F, 16'h00F1, 1'b1);
        repeat (3) begin
            in_a = 16'($urandom);
            in_b = 16'($urandom);
            in_cin = 1'($urandom);
            @(posedge clk); #1;
        end
        drain();

        // Random back-to-back with random backpressure
        rdy_mode = 1;
        repeat (50) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom));
        end
        drain();
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("result_count", 32'(n_pop), 32'(n_push - n_flush));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
